// File: rtl/mmio_io_unit_pkg.sv
// Shared address map and status layout for the MMIO I/O slave.
package mmio_io_unit_pkg;

  // Offsets within the 0x8000_0000 I/O region (io_addr[11:0]).
  localparam logic [11:0] IO_UART_CTRL = 12'h000;
  localparam logic [11:0] IO_UART_RX   = 12'h004;
  localparam logic [11:0] IO_UART_TX   = 12'h008;
  localparam logic [11:0] IO_CNT_CLR   = 12'h018;
  localparam logic [11:0] IO_CNT_BASE  = 12'h020;

  // io_addr[31:30] that selects this block.
  localparam logic [1:0]  IO_REGION    = 2'b10;

  typedef struct packed {
    logic tx_drop;
    logic rx_drop;
    logic rx_nonempty;
    logic tx_free;
  } io_status_t;

  function automatic logic [31:0] status_word(input io_status_t s);
    return {28'b0, s};
  endfunction

endpackage

// File: rtl/mmio_io_unit_if.sv
// CPU-side MMIO request/response bus.
interface mmio_io_unit_if;
  logic [31:0] io_addr;
  logic        io_re;
  logic        io_we;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;

  modport master (output io_addr, io_re, io_we, io_wdata, input io_rdata);
  modport slave  (input io_addr, io_re, io_we, io_wdata, output io_rdata);
endinterface

// File: rtl/mmio_io_unit_sync_fifo.sv
// Single-clock FIFO, pointer + occupancy count; push and pop may share a cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next-state: write slot, advance pointers (DEPTH is a power of 2, so they wrap naturally).
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
  end

  // Pointer/count state, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; contents are only visible when count is nonzero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/mmio_io_unit.sv
// MMIO slave: UART RX FIFO, TX holding register, event counters, registered read data.
module mmio_io_unit
  import mmio_io_unit_pkg::*;
#(
  parameter int NUM_CNT   = 4,
  parameter int CNT_WIDTH = 32,
  parameter int RX_DEPTH  = 8
) (
  input  logic               clk,
  input  logic               rst,
  mmio_io_unit_if.slave      bus,
  input  logic [NUM_CNT-1:0] cnt_inc,
  input  logic [7:0]         uart_rx_data_out,
  input  logic               uart_rx_data_out_valid,
  output logic               uart_rx_data_out_ready,
  output logic [7:0]         uart_tx_data_in,
  output logic               uart_tx_data_in_valid,
  input  logic               uart_tx_data_in_ready
);
  logic        hit;
  logic [11:0] off;
  logic [9:0]  cnt_idx;
  logic        cnt_hit;
  logic        rd_rx, wr_ctrl, wr_tx, wr_clr;

  logic        fifo_full, fifo_empty;
  logic [7:0]  fifo_dout;

  logic [31:0] rdata_q, rdata_d, rd_val;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_drop_q, tx_drop_d, rx_drop_q, rx_drop_d;
  logic        tx_hs;

  logic [31:0] cnt_rd [NUM_CNT];
  logic        unused_bits;

  assign hit     = (bus.io_addr[31:30] == IO_REGION);
  assign off     = bus.io_addr[11:0];
  assign cnt_hit = (off >= IO_CNT_BASE) && (off[1:0] == 2'b00);
  assign cnt_idx = 10'((off - IO_CNT_BASE) >> 2);
  assign rd_rx   = bus.io_re && hit && (off == IO_UART_RX);
  assign wr_ctrl = bus.io_we && hit && (off == IO_UART_CTRL);
  assign wr_tx   = bus.io_we && hit && (off == IO_UART_TX);
  assign wr_clr  = bus.io_we && hit && (off == IO_CNT_CLR);
  assign tx_hs   = tx_valid_q && uart_tx_data_in_ready;

  assign unused_bits = ^{bus.io_addr[29:12], bus.io_wdata[31:8], cnt_inc[0]};

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (uart_rx_data_out_valid),
    .din   (uart_rx_data_out),
    .pop   (rd_rx),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Ready comes straight from registered occupancy, so a byte offered while ready is always stored.
  assign uart_rx_data_out_ready = !fifo_full;
  assign uart_tx_data_in        = tx_data_q;
  assign uart_tx_data_in_valid  = tx_valid_q;
  assign bus.io_rdata           = rdata_q;

  // Event counters; counter 0 is a free-running cycle counter. Clear beats increment.
  for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 inc;
    assign inc = (k == 0) ? 1'b1 : cnt_inc[k];

    // Next counter value: clear, increment (wrapping) or hold.
    always_comb begin
      cnt_d = cnt_q;
      if (wr_clr)   cnt_d = '0;
      else if (inc) cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    // Counter register.
    always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end

    assign cnt_rd[k] = 32'(cnt_q);
  end

  // Read mux over pre-update state; unmapped offsets and other regions read 0.
  always_comb begin
    rd_val = '0;
    if (hit) begin
      if (off == IO_UART_CTRL)
        rd_val = status_word('{tx_drop: tx_drop_q, rx_drop: rx_drop_q,
                               rx_nonempty: !fifo_empty, tx_free: !tx_valid_q});
      else if (off == IO_UART_RX)
        rd_val = fifo_empty ? 32'h0 : {24'h0, fifo_dout};
      else if (cnt_hit)
        for (int k = 0; k < NUM_CNT; k++)
          if (cnt_idx == 10'(k)) rd_val = cnt_rd[k];
    end
  end

  // Control next-state: read capture, TX holding register, sticky drop flags.
  always_comb begin
    rdata_d    = rdata_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tx_drop_d  = tx_drop_q;
    rx_drop_d  = rx_drop_q;
    if (bus.io_re) rdata_d = rd_val;
    // A handshake in the same cycle frees the slot for the incoming byte.
    if (wr_tx) begin
      if (!tx_valid_q || tx_hs) begin
        tx_data_d  = bus.io_wdata[7:0];
        tx_valid_d = 1'b1;
      end else begin
        tx_drop_d  = 1'b1;
      end
    end else if (tx_hs) begin
      tx_valid_d = 1'b0;
    end
    if (wr_ctrl) begin
      tx_drop_d = 1'b0;
      rx_drop_d = 1'b0;
    end
    if (rd_rx && fifo_empty) rx_drop_d = 1'b1;
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_drop_q  <= 1'b0;
      rx_drop_q  <= 1'b0;
    end else begin
      rdata_q    <= rdata_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_drop_q  <= tx_drop_d;
      rx_drop_q  <= rx_drop_d;
    end
  end
endmodule
